// File: rtl/angle_uart_reporter_if.sv
// Byte stream from the angle reporter to the debug UART transmitter.
// A transfer occurs on a cycle where byte_valid_out and byte_ready_in are both high.
interface angle_uart_reporter_if;
  logic [7:0] byte_out;
  logic       byte_valid_out;
  logic       byte_ready_in;

  modport master (
    output byte_out,
    output byte_valid_out,
    input  byte_ready_in
  );

  modport slave (
    input  byte_out,
    input  byte_valid_out,
    output byte_ready_in
  );
endinterface

// File: rtl/angle_uart_reporter.sv
// Formats a steering angle as an ASCII line ("A:127\r\n") for the debug UART.
// Leading zeros are suppressed, angles above 180 print "---", newest pending angle wins.
module angle_uart_reporter #(
  parameter bit          PREFIX_EN  = 1'b1,
  parameter bit          CRLF_EN    = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [7:0]                   angle_in,
  input  logic                         angle_valid_in,
  angle_uart_reporter_if.master        tx,
  output logic                         busy_out,
  output logic                         overwrite_out
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_LOAD = 4'd1;
  localparam logic [3:0] S_PA   = 4'd2;
  localparam logic [3:0] S_PC   = 4'd3;
  localparam logic [3:0] S_HUND = 4'd4;
  localparam logic [3:0] S_TENS = 4'd5;
  localparam logic [3:0] S_ONES = 4'd6;
  localparam logic [3:0] S_CR   = 4'd7;
  localparam logic [3:0] S_LF   = 4'd8;
  localparam logic [3:0] S_GAP  = 4'd9;

  logic [3:0]  state;
  logic [7:0]  angle_q;
  logic [3:0]  hund_q;
  logic [3:0]  tens_q;
  logic [3:0]  ones_q;
  logic        oor_q;
  logic [7:0]  pend_q;
  logic        pend_full;
  logic        ovw_q;
  logic [15:0] gap_q;

  logic [7:0]  rem_h;
  logic [7:0]  rem_t;
  logic [3:0]  hund_c;
  logic [3:0]  tens_c;
  logic [3:0]  ones_c;
  logic        oor_c;

  logic        xfer;
  logic        vld;
  logic [7:0]  chr;

  // Binary to BCD by comparison; the range is small enough for a flat search.
  always_comb begin
    hund_c = 4'd0;
    rem_h  = angle_q;
    if (angle_q >= 8'd200) begin
      hund_c = 4'd2;
      rem_h  = angle_q - 8'd200;
    end else if (angle_q >= 8'd100) begin
      hund_c = 4'd1;
      rem_h  = angle_q - 8'd100;
    end
    tens_c = 4'd0;
    for (int i = 1; i < 10; i++) begin
      if (rem_h >= 8'(10 * i)) tens_c = 4'(i);
    end
    rem_t  = rem_h - ({4'd0, tens_c} << 3)
                   - ({4'd0, tens_c} << 1);
    ones_c = rem_t[3:0];
    oor_c  = angle_q > 8'd180;
  end

  function automatic logic [3:0] first_digit(
    input logic       oor,
    input logic [3:0] h,
    input logic [3:0] t
  );
    if (oor || h != 4'd0) return S_HUND;
    else if (t != 4'd0) return S_TENS;
    else return S_ONES;
  endfunction

  assign xfer = vld && tx.byte_ready_in;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state     <= S_IDLE;
      angle_q   <= 8'd0;
      hund_q    <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      oor_q     <= 1'b0;
      pend_q    <= 8'd0;
      pend_full <= 1'b0;
      ovw_q     <= 1'b0;
      gap_q     <= 16'd0;
    end else begin
      ovw_q <= 1'b0;
      if (angle_valid_in && state != S_IDLE) begin
        pend_q    <= angle_in;
        pend_full <= 1'b1;
        ovw_q     <= pend_full;
      end
      case (state)
        S_IDLE: begin
          if (angle_valid_in) begin
            angle_q   <= angle_in;
            pend_full <= 1'b0;
            state     <= S_LOAD;
          end else if (pend_full) begin
            angle_q   <= pend_q;
            pend_full <= 1'b0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          hund_q <= hund_c;
          tens_q <= tens_c;
          ones_q <= ones_c;
          oor_q  <= oor_c;
          state  <= PREFIX_EN ? S_PA
                              : first_digit(oor_c, hund_c, tens_c);
        end
        S_PA:   if (xfer) state <= S_PC;
        S_PC:   if (xfer) state <= first_digit(oor_q, hund_q, tens_q);
        S_HUND: if (xfer) state <= S_TENS;
        S_TENS: if (xfer) state <= S_ONES;
        S_ONES: if (xfer) state <= CRLF_EN ? S_CR : S_LF;
        S_CR:   if (xfer) state <= S_LF;
        S_LF: begin
          if (xfer) begin
            if (GAP_CYCLES != 0) begin
              state <= S_GAP;
              gap_q <= 16'(GAP_CYCLES);
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          gap_q <= gap_q - 16'd1;
          if (gap_q <= 16'd1) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Character is a pure function of state and the registered digits,
  // so it cannot change while a transfer is stalled.
  always_comb begin
    vld = 1'b0;
    chr = 8'h00;
    case (state)
      S_PA: begin
        vld = 1'b1;
        chr = 8'h41;
      end
      S_PC: begin
        vld = 1'b1;
        chr = 8'h3a;
      end
      S_HUND: begin
        vld = 1'b1;
        chr = oor_q ? 8'h2d : {4'h3, hund_q};
      end
      S_TENS: begin
        vld = 1'b1;
        chr = oor_q ? 8'h2d : {4'h3, tens_q};
      end
      S_ONES: begin
        vld = 1'b1;
        chr = oor_q ? 8'h2d : {4'h3, ones_q};
      end
      S_CR: begin
        vld = 1'b1;
        chr = 8'h0d;
      end
      S_LF: begin
        vld = 1'b1;
        chr = 8'h0a;
      end
      default: begin
        vld = 1'b0;
        chr = 8'h00;
      end
    endcase
  end

  assign tx.byte_out       = chr;
  assign tx.byte_valid_out = vld;
  assign busy_out          = state != S_IDLE;
  assign overwrite_out     = ovw_q;

endmodule
